// File: rtl/ray_frame_scheduler_if.sv
// Bus between the frame scheduler and its surroundings: frame control,
// live/snapshotted block positions, pixel requests and credit returns.
interface ray_frame_scheduler_if #(
   parameter int NUM_BLOCKS   = 12,
   parameter int MAX_INFLIGHT = 200
);
   localparam int CW = $clog2(MAX_INFLIGHT + 1);

   logic                         start_in;
   logic [NUM_BLOCKS-1:0][11:0]  block_x_in;
   logic [NUM_BLOCKS-1:0][11:0]  block_y_in;
   logic [NUM_BLOCKS-1:0][13:0]  block_z_in;
   logic                         result_valid_in;
   logic [NUM_BLOCKS-1:0][11:0]  block_x_out;
   logic [NUM_BLOCKS-1:0][11:0]  block_y_out;
   logic [NUM_BLOCKS-1:0][13:0]  block_z_out;
   logic [10:0]                  x_out;
   logic [9:0]                   y_out;
   logic                         valid_out;
   logic [CW-1:0]                in_flight_out;
   logic                         busy_out;
   logic                         frame_done_out;
   logic                         underflow_out;

   // Drives frame control and block positions, consumes requests
   modport master (
      output start_in, block_x_in, block_y_in, block_z_in, result_valid_in,
      input  block_x_out, block_y_out, block_z_out, x_out, y_out, valid_out,
             in_flight_out, busy_out, frame_done_out, underflow_out
   );

   // The scheduler side
   modport slave (
      input  start_in, block_x_in, block_y_in, block_z_in, result_valid_in,
      output block_x_out, block_y_out, block_z_out, x_out, y_out, valid_out,
             in_flight_out, busy_out, frame_done_out, underflow_out
   );
endinterface

// File: rtl/ray_frame_scheduler.sv
// Frame scheduler: snapshots block positions at frame start, issues pixel
// requests in raster order under a credit limit, and pulses done once every
// issued pixel has come back from the intersection pipeline.
module ray_frame_scheduler #(
   parameter int H_PIXELS     = 1024,
   parameter int V_PIXELS     = 768,
   parameter int MAX_INFLIGHT = 200,
   parameter int NUM_BLOCKS   = 12
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   ray_frame_scheduler_if.slave  bus
);
   localparam int CW = $clog2(MAX_INFLIGHT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                       state_q, state_d;
   logic [10:0]                  px_q, px_d;
   logic [9:0]                   py_q, py_d;
   logic [10:0]                  x_q, x_d;
   logic [9:0]                   y_q, y_d;
   logic                         valid_q, valid_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;
   logic                         underflow_q, underflow_d;
   logic [NUM_BLOCKS-1:0][11:0]  bx_q, bx_d;
   logic [NUM_BLOCKS-1:0][11:0]  by_q, by_d;
   logic [NUM_BLOCKS-1:0][13:0]  bz_q, bz_d;
   logic                         issue;

   // Next-state logic: frame sequencing, pixel counter, credits and flags
   always_comb begin
      state_d     = state_q;
      px_d        = px_q;
      py_d        = py_q;
      x_d         = x_q;
      y_d         = y_q;
      valid_d     = 1'b0;
      cnt_d       = cnt_q;
      underflow_d = underflow_q;
      bx_d        = bx_q;
      by_d        = by_q;
      bz_d        = bz_q;
      issue       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start_in) begin
               state_d     = S_LATCH;
               underflow_d = 1'b0;
            end
         end
         S_LATCH: begin
            bx_d    = bus.block_x_in;
            by_d    = bus.block_y_in;
            bz_d    = bus.block_z_in;
            px_d    = '0;
            py_d    = '0;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (cnt_q < CW'(MAX_INFLIGHT)) begin
               issue   = 1'b1;
               valid_d = 1'b1;
               x_d     = px_q;
               y_d     = py_q;
               if (px_q == 11'(H_PIXELS - 1)) begin
                  px_d = '0;
                  if (py_q == 10'(V_PIXELS - 1)) begin
                     state_d = S_DRAIN;
                  end else begin
                     py_d = py_q + 10'd1;
                  end
               end else begin
                  px_d = px_q + 11'd1;
               end
            end
         end
         S_DRAIN: begin
            state_d = S_DRAIN;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Issue and return in the same cycle cancel; a return with nothing
      // outstanding is flagged rather than wrapping the counter.
      if (issue && !bus.result_valid_in) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!issue && bus.result_valid_in) begin
         if (cnt_q == '0) begin
            underflow_d = 1'b1;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end

      // Drain completes on the edge whose updated count reaches zero
      if (state_q == S_DRAIN && cnt_d == '0) begin
         state_d = S_DONE;
      end

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= S_IDLE;
         px_q        <= '0;
         py_q        <= '0;
         x_q         <= '0;
         y_q         <= '0;
         valid_q     <= 1'b0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         underflow_q <= 1'b0;
         bx_q        <= '0;
         by_q        <= '0;
         bz_q        <= '0;
      end else begin
         state_q     <= state_d;
         px_q        <= px_d;
         py_q        <= py_d;
         x_q         <= x_d;
         y_q         <= y_d;
         valid_q     <= valid_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         underflow_q <= underflow_d;
         bx_q        <= bx_d;
         by_q        <= by_d;
         bz_q        <= bz_d;
      end
   end

   assign bus.block_x_out    = bx_q;
   assign bus.block_y_out    = by_q;
   assign bus.block_z_out    = bz_q;
   assign bus.x_out          = x_q;
   assign bus.y_out          = y_q;
   assign bus.valid_out      = valid_q;
   assign bus.in_flight_out  = cnt_q;
   assign bus.busy_out       = busy_q;
   assign bus.frame_done_out = done_q;
   assign bus.underflow_out  = underflow_q;
endmodule
